// File: rtl/bus_dma.sv
// Second bus master: copies a block of words between two word addresses, or fills
// a block with a constant. Copy is read-then-write per word; fill writes every cycle.
module bus_dma #(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic [29:0]        src_addr,
  input  logic [29:0]        dst_addr,
  input  logic [COUNT_W-1:0] count,
  input  logic [31:0]        fill_value,
  output logic               busy,
  output logic               done,
  output logic [29:0]        bus_addr,
  input  logic [31:0]        bus_data_r,
  output logic [31:0]        bus_data_w,
  output logic [3:0]         bus_mask_w
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_FINISH
  } state_t;

  state_t             state;
  logic [29:0]        src;
  logic [29:0]        dst;
  logic [COUNT_W-1:0] remaining;
  logic               fill_mode;
  logic [31:0]        data_q;

  logic [29:0] src_inc;
  logic [29:0] dst_inc;

  assign src_inc = src + 30'd1;
  assign dst_inc = dst + 30'd1;

  // Copy data is forwarded straight from the responder's registered read port;
  // the read issued in the Read cycle lands on bus_data_r during Write.
  assign bus_data_w = (state == S_WRITE && !fill_mode) ? bus_data_r : data_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      src        <= '0;
      dst        <= '0;
      remaining  <= '0;
      fill_mode  <= 1'b0;
      data_q     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bus_addr   <= '0;
      bus_mask_w <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done       <= 1'b0;
          bus_addr   <= '0;
          bus_mask_w <= '0;
          data_q     <= '0;
          if (start) begin
            src       <= src_addr;
            dst       <= dst_addr;
            remaining <= count;
            fill_mode <= mode;
            if (count == '0) begin
              state <= S_FINISH;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (mode) begin
              state      <= S_WRITE;
              busy       <= 1'b1;
              bus_addr   <= dst_addr;
              bus_mask_w <= '1;
              data_q     <= fill_value;
            end else begin
              state    <= S_READ;
              busy     <= 1'b1;
              bus_addr <= src_addr;
            end
          end
        end

        S_READ: begin
          state      <= S_WRITE;
          bus_addr   <= dst;
          bus_mask_w <= '1;
        end

        S_WRITE: begin
          dst       <= dst_inc;
          remaining <= remaining - COUNT_W'(1);
          if (!fill_mode) begin
            src <= src_inc;
          end
          if (remaining == COUNT_W'(1)) begin
            state      <= S_FINISH;
            busy       <= 1'b0;
            done       <= 1'b1;
            bus_addr   <= '0;
            bus_mask_w <= '0;
            data_q     <= '0;
          end else if (fill_mode) begin
            bus_addr <= dst_inc;
          end else begin
            state      <= S_READ;
            bus_addr   <= src_inc;
            bus_mask_w <= '0;
          end
        end

        S_FINISH: begin
          state      <= S_IDLE;
          done       <= 1'b0;
          busy       <= 1'b0;
          bus_addr   <= '0;
          bus_mask_w <= '0;
        end

        default: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          done       <= 1'b0;
          bus_addr   <= '0;
          bus_mask_w <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_dma.sv
// Directed bench for bus_dma with a registered-read memory model and a write log.
module tb_bus_dma;

  logic        clock;
  logic        reset;
  logic        start;
  logic        mode;
  logic [29:0] src_addr;
  logic [29:0] dst_addr;
  logic [15:0] count;
  logic [31:0] fill_value;
  logic        busy;
  logic        done;
  logic [29:0] bus_addr;
  logic [31:0] bus_data_r;
  logic [31:0] bus_data_w;
  logic [3:0]  bus_mask_w;

  int unsigned n_cmp;
  int unsigned n_bad;

  logic [31:0] mem [logic [29:0]];
  logic [29:0] wr_addr [$];
  logic [31:0] wr_data [$];

  bus_dma #(.COUNT_W(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .count      (count),
    .fill_value (fill_value),
    .busy       (busy),
    .done       (done),
    .bus_addr   (bus_addr),
    .bus_data_r (bus_data_r),
    .bus_data_w (bus_data_w),
    .bus_mask_w (bus_mask_w)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (bus_mask_w != 4'b0000) begin
      mem[bus_addr] = bus_data_w;
      wr_addr.push_back(bus_addr);
      wr_data.push_back(bus_data_w);
    end
  end

  always @(posedge clock) begin
    bus_data_r <= mem.exists(bus_addr) ? mem[bus_addr] : 32'h0;
  end

  function automatic logic [31:0] rd(input logic [29:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // Assert start for one edge; returns at the negedge of cycle 1 (first cycle after the start edge).
  task automatic do_start(input logic m, input logic [29:0] s, input logic [29:0] d,
                          input logic [15:0] c, input logic [31:0] f);
    @(negedge clock);
    start = 1'b1; mode = m; src_addr = s; dst_addr = d; count = c; fill_value = f;
    @(negedge clock);
    start = 1'b0; mode = ~m; src_addr = 30'h1234; dst_addr = 30'h2345; count = 16'h7; fill_value = 32'hBAD0_BAD0;
  endtask

  // Observe ncyc cycles; optionally re-pulse start (with other args) in cycles pa and pb.
  task automatic watch(input int unsigned ncyc, input int unsigned pa, input int unsigned pb,
                       output int unsigned first_done, output int unsigned done_cnt,
                       output int unsigned busy_cnt);
    first_done = 0; done_cnt = 0; busy_cnt = 0;
    for (int unsigned c = 1; c <= ncyc; c++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (first_done == 0) first_done = c;
      end
      if (c == pa || c == pb) begin
        start = 1'b1; mode = 1'b1; dst_addr = 30'h90; count = 16'd2; fill_value = 32'hFFFF_0000;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0; count = '0; fill_value = '0;
    repeat (2) @(negedge clock);
    n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL reset_busy_done got %b want 00", {busy, done}); end
    n_cmp++; if (bus_addr !== 30'h0) begin n_bad++; $display("FAIL reset_addr got %h want 0", bus_addr); end
    n_cmp++; if (bus_mask_w !== 4'h0) begin n_bad++; $display("FAIL reset_mask got %h want 0", bus_mask_w); end
    n_cmp++; if (bus_data_w !== 32'h0) begin n_bad++; $display("FAIL reset_wdata got %h want 0", bus_data_w); end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_copy4;
    int unsigned fd, dc, bc;
    for (int unsigned i = 0; i < 4; i++) mem[30'h10 + 30'(i)] = 32'hA0 + 32'(i);
    wr_addr.delete(); wr_data.delete();
    do_start(1'b0, 30'h10, 30'h40, 16'd4, 32'h0);
    watch(14, 0, 0, fd, dc, bc);
    n_cmp++; if (fd !== 9) begin n_bad++; $display("FAIL copy_done_cycle got %0d want 9", fd); end
    n_cmp++; if (dc !== 1) begin n_bad++; $display("FAIL copy_done_pulses got %0d want 1", dc); end
    n_cmp++; if (bc !== 8) begin n_bad++; $display("FAIL copy_busy_cycles got %0d want 8", bc); end
    n_cmp++; if (wr_addr.size() !== 4) begin n_bad++; $display("FAIL copy_write_count got %0d want 4", wr_addr.size()); end
    for (int unsigned i = 0; i < 4; i++) begin
      n_cmp++;
      if (rd(30'h40 + 30'(i)) !== 32'hA0 + 32'(i)) begin
        n_bad++; $display("FAIL copy_word%0d got %h want %h", i, rd(30'h40 + 30'(i)), 32'hA0 + 32'(i));
      end
    end
    if (wr_addr.size() == 4) begin
      n_cmp++; if (wr_addr[3] !== 30'h43) begin n_bad++; $display("FAIL copy_last_addr got %h want 43", wr_addr[3]); end
    end
  endtask

  task automatic test_fill;
    int unsigned fd, dc, bc;
    mem[30'h23] = 32'h1234_5678;
    wr_addr.delete(); wr_data.delete();
    do_start(1'b1, 30'h0, 30'h20, 16'd3, 32'hDEAD_BEEF);
    watch(8, 0, 0, fd, dc, bc);
    n_cmp++; if (fd !== 4) begin n_bad++; $display("FAIL fill_done_cycle got %0d want 4", fd); end
    n_cmp++; if (bc !== 3) begin n_bad++; $display("FAIL fill_busy_cycles got %0d want 3", bc); end
    n_cmp++; if (wr_addr.size() !== 3) begin n_bad++; $display("FAIL fill_write_count got %0d want 3", wr_addr.size()); end
    for (int unsigned i = 0; i < 3; i++) begin
      n_cmp++;
      if (rd(30'h20 + 30'(i)) !== 32'hDEAD_BEEF) begin
        n_bad++; $display("FAIL fill_word%0d got %h want deadbeef", i, rd(30'h20 + 30'(i)));
      end
    end
    n_cmp++; if (rd(30'h23) !== 32'h1234_5678) begin n_bad++; $display("FAIL fill_beyond got %h want 12345678", rd(30'h23)); end
  endtask

  task automatic test_count0;
    int unsigned fd, dc, bc;
    wr_addr.delete(); wr_data.delete();
    do_start(1'b0, 30'h10, 30'h50, 16'd0, 32'h0);
    watch(6, 0, 0, fd, dc, bc);
    n_cmp++; if (fd !== 1) begin n_bad++; $display("FAIL zero_done_cycle got %0d want 1", fd); end
    n_cmp++; if (dc !== 1) begin n_bad++; $display("FAIL zero_done_pulses got %0d want 1", dc); end
    n_cmp++; if (bc !== 0) begin n_bad++; $display("FAIL zero_busy_cycles got %0d want 0", bc); end
    n_cmp++; if (wr_addr.size() !== 0) begin n_bad++; $display("FAIL zero_writes got %0d want 0", wr_addr.size()); end
  endtask

  task automatic test_wrap;
    int unsigned fd, dc, bc;
    wr_addr.delete(); wr_data.delete();
    do_start(1'b1, 30'h0, 30'h3FFF_FFFF, 16'd2, 32'h5);
    watch(6, 0, 0, fd, dc, bc);
    n_cmp++;
    if (wr_addr.size() !== 2) begin
      n_bad++; $display("FAIL wrap_write_count got %0d want 2", wr_addr.size());
    end else begin
      n_cmp++; if (wr_addr[0] !== 30'h3FFF_FFFF) begin n_bad++; $display("FAIL wrap_addr0 got %h want 3fffffff", wr_addr[0]); end
      n_cmp++; if (wr_addr[1] !== 30'h0) begin n_bad++; $display("FAIL wrap_addr1 got %h want 0", wr_addr[1]); end
      n_cmp++; if (wr_data[1] !== 32'h5) begin n_bad++; $display("FAIL wrap_data got %h want 5", wr_data[1]); end
    end
    n_cmp++; if (fd !== 3) begin n_bad++; $display("FAIL wrap_done_cycle got %0d want 3", fd); end
  endtask

  task automatic test_back_to_back;
    int unsigned fd, dc, bc;
    wr_addr.delete(); wr_data.delete();
    do_start(1'b0, 30'h10, 30'h80, 16'd4, 32'h0);
    // start re-pulsed mid-copy and again in the Finish cycle
    watch(16, 3, 9, fd, dc, bc);
    n_cmp++; if (dc !== 1) begin n_bad++; $display("FAIL b2b_done_pulses got %0d want 1", dc); end
    n_cmp++; if (fd !== 9) begin n_bad++; $display("FAIL b2b_done_cycle got %0d want 9", fd); end
    n_cmp++; if (wr_addr.size() !== 4) begin n_bad++; $display("FAIL b2b_write_count got %0d want 4", wr_addr.size()); end
    n_cmp++; if (rd(30'h83) !== 32'hA3) begin n_bad++; $display("FAIL b2b_last_word got %h want a3", rd(30'h83)); end
    n_cmp++; if (mem.exists(30'h90)) begin n_bad++; $display("FAIL b2b_second_started got write at 90 want none"); end
  endtask

  task automatic test_reset_abort;
    int unsigned fd, dc, bc;
    wr_addr.delete(); wr_data.delete();
    do_start(1'b0, 30'h10, 30'hA0, 16'd4, 32'h0);
    repeat (3) @(negedge clock);          // now in cycle 4: second Write
    n_cmp++; if (bus_mask_w !== 4'hF) begin n_bad++; $display("FAIL abort_in_write got mask %h want f", bus_mask_w); end
    #1 reset = 1'b0;
    #1;
    n_cmp++; if (bus_mask_w !== 4'h0) begin n_bad++; $display("FAIL abort_mask got %h want 0", bus_mask_w); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", busy); end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    n_cmp++; if (wr_addr.size() !== 1) begin n_bad++; $display("FAIL abort_write_count got %0d want 1", wr_addr.size()); end
    n_cmp++; if (mem.exists(30'hA1)) begin n_bad++; $display("FAIL abort_extra_write got %h at a1 want none", rd(30'hA1)); end
    wr_addr.delete(); wr_data.delete();
    do_start(1'b0, 30'h10, 30'hB0, 16'd2, 32'h0);
    watch(8, 0, 0, fd, dc, bc);
    n_cmp++; if (fd !== 5) begin n_bad++; $display("FAIL after_abort_done_cycle got %0d want 5", fd); end
    n_cmp++; if (rd(30'hB1) !== 32'hA1) begin n_bad++; $display("FAIL after_abort_word got %h want a1", rd(30'hB1)); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_copy4();
    test_fill();
    test_count0();
    test_wrap();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
